// File: rtl/axis_loader_pkg.sv
// Shared definitions for the ifmap AXIS loader and the preload FIFO:
// FSM state encoding, beat packing constants and the row-end rule.
package axis_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_e;

  localparam int unsigned LOADER_CH_PER_BEAT = 6;
  localparam int unsigned LOADER_PAYLOAD_W   = 30;

  // A beat closes its row when it would carry the channel count past cfg_ch.
  function automatic logic row_end(input logic [12:0] ch_cnt, input logic [11:0] cfg_ch);
    return (ch_cnt + 13'(LOADER_CH_PER_BEAT)) > {1'b0, cfg_ch};
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid buffer with valid/ready on both sides.
// Push and pop may happen in the same cycle; flush empties it synchronously.
module axis_skid_buffer #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push, pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_data;
      end
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      count_d  = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/axis_ifmap_loader.sv
// AXI4-Stream slave front end for the ifmap preload FIFO with frame/row counting
// and tlast checking. Optional stall counter built when AXIS_LOADER_PERF_EN is defined.
module axis_ifmap_loader
  import axis_loader_pkg::*;
#(
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned ROW_CNT_W            = 16,
  parameter int unsigned PERF_CNT_W           = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  input  logic                            start,
  input  logic                            abort,
  input  logic [11:0]                     input_channel_size,
  input  logic [ROW_CNT_W-1:0]            cfg_rows,
  input  logic                            fifo_full,
  input  logic                            fifo_empty,
  input  logic                            fifo_read,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] ifmaps_from_axis,
  output logic                            load_axis_preload,
  output logic                            axis_clear,
  output logic                            busy,
  output logic                            done,
  output logic                            err_tlast,
  output logic [PERF_CNT_W-1:0]           stall_cnt
);

  localparam int unsigned SKID_W = C_S_AXIS_TDATA_WIDTH + 1;

  loader_state_e          state_q, state_d;
  logic [11:0]            cfg_ch_q, cfg_ch_d;
  logic [ROW_CNT_W-1:0]   rows_q, rows_d;
  logic [ROW_CNT_W-1:0]   row_cnt_q, row_cnt_d;
  logic [12:0]            ch_cnt_q, ch_cnt_d;
  logic                   clear_q, clear_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic [SKID_W-1:0]      skid_in, skid_out;
  logic                   skid_in_valid, skid_in_ready;
  logic                   skid_out_valid, skid_out_ready;
  logic                   loading, active, preload_ready, accept;
  logic                   head_tlast, final_pop, tlast_bad;

  assign loading        = (state_q == ST_LOAD);
  assign active         = loading | (state_q == ST_DRAIN);
  assign preload_ready  = ~fifo_full | (fifo_read & ~fifo_empty);

  assign s_axis_tready  = loading & skid_in_ready & ~abort;
  assign accept         = s_axis_tvalid & s_axis_tready;
  assign skid_in        = {s_axis_tlast, s_axis_tdata};
  assign skid_in_valid  = s_axis_tvalid & loading & ~abort;
  assign skid_out_ready = active & preload_ready & ~abort;

  assign load_axis_preload = skid_out_valid & skid_out_ready;
  assign ifmaps_from_axis  = skid_out[C_S_AXIS_TDATA_WIDTH-1:0];
  assign head_tlast        = skid_out[SKID_W-1];

  // tlast is checked as each beat leaves the skid. The final beat is the only
  // one ever popped in DRAIN with a single entry left (nothing is pushed there).
  assign final_pop = (state_q == ST_DRAIN) & skid_in_ready;
  assign tlast_bad = load_axis_preload & (head_tlast ^ final_pop);

  axis_skid_buffer #(
    .WIDTH(SKID_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (abort),
    .in_data  (skid_in),
    .in_valid (skid_in_valid),
    .in_ready (skid_in_ready),
    .out_data (skid_out),
    .out_valid(skid_out_valid),
    .out_ready(skid_out_ready)
  );

  always_comb begin
    state_d   = state_q;
    cfg_ch_d  = cfg_ch_q;
    rows_d    = rows_q;
    row_cnt_d = row_cnt_q;
    ch_cnt_d  = ch_cnt_q;
    err_d     = err_q;
    clear_d   = 1'b0;
    done_d    = 1'b0;
    if (abort) begin
      state_d   = ST_IDLE;
      ch_cnt_d  = '0;
      row_cnt_d = '0;
      clear_d   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cfg_ch_d  = input_channel_size;
            rows_d    = cfg_rows;
            ch_cnt_d  = '0;
            row_cnt_d = '0;
            clear_d   = 1'b1;
            err_d     = 1'b0;
            if (cfg_rows == '0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (row_end(ch_cnt_q, cfg_ch_q)) begin
              ch_cnt_d  = '0;
              row_cnt_d = row_cnt_q + ROW_CNT_W'(1);
              if (row_cnt_q == rows_q - ROW_CNT_W'(1)) begin
                state_d = ST_DRAIN;
              end
            end else begin
              ch_cnt_d = ch_cnt_q + 13'(LOADER_CH_PER_BEAT);
            end
          end
        end
        ST_DRAIN: begin
          if (!skid_out_valid) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
      if (tlast_bad) begin
        err_d = 1'b1;
      end
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cfg_ch_q  <= '0;
      rows_q    <= '0;
      row_cnt_q <= '0;
      ch_cnt_q  <= '0;
      clear_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_ch_q  <= cfg_ch_d;
      rows_q    <= rows_d;
      row_cnt_q <= row_cnt_d;
      ch_cnt_q  <= ch_cnt_d;
      clear_q   <= clear_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign axis_clear = clear_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_tlast  = err_q;

`ifdef AXIS_LOADER_PERF_EN
  logic [PERF_CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == ST_IDLE) && start && !abort) begin
      stall_d = '0;
    end else if (skid_out_valid && !preload_ready && (state_q != ST_IDLE) && (stall_q != '1)) begin
      stall_d = stall_q + PERF_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_axis_ifmap_loader.sv
// Directed self-checking bench for axis_ifmap_loader; stall_cnt expectations
// follow the AXIS_LOADER_PERF_EN define.
module tb_axis_ifmap_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic        start;
  logic        abort;
  logic [11:0] input_channel_size;
  logic [15:0] cfg_rows;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_read;
  logic [31:0] ifmaps_from_axis;
  logic        load_axis_preload;
  logic        axis_clear;
  logic        busy;
  logic        done;
  logic        err_tlast;
  logic [31:0] stall_cnt;

`ifdef AXIS_LOADER_PERF_EN
  localparam logic [31:0] EXP_STALL7 = 32'd7;
`else
  localparam logic [31:0] EXP_STALL7 = 32'd0;
`endif

  int vec  = 0;
  int miss = 0;
  int done_cnt  = 0;
  int clear_cnt = 0;
  int rdy_cnt   = 0;
  int hold_cnt  = 0;
  logic [31:0] got_q [$];
  logic [31:0] base;

  axis_ifmap_loader #(
    .C_S_AXIS_TDATA_WIDTH(32),
    .ROW_CNT_W(16),
    .PERF_CNT_W(32)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tready     (s_axis_tready),
    .start             (start),
    .abort             (abort),
    .input_channel_size(input_channel_size),
    .cfg_rows          (cfg_rows),
    .fifo_full         (fifo_full),
    .fifo_empty        (fifo_empty),
    .fifo_read         (fifo_read),
    .ifmaps_from_axis  (ifmaps_from_axis),
    .load_axis_preload (load_axis_preload),
    .axis_clear        (axis_clear),
    .busy              (busy),
    .done              (done),
    .err_tlast         (err_tlast),
    .stall_cnt         (stall_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load_axis_preload) got_q.push_back(ifmaps_from_axis);
    if (done) done_cnt++;
    if (axis_clear) clear_cnt++;
    if (s_axis_tready) rdy_cnt++;
    if (busy && s_axis_tvalid && !s_axis_tready) hold_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [11:0] ch, input logic [15:0] rows);
    start = 1'b1;
    input_channel_size = ch;
    cfg_rows = rows;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input int idx, input logic last);
    bit ok = 1'b0;
    s_axis_tdata  = base + 32'(idx);
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("beat_accept_timeout", 32'(ok), 32'd1);
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_range(input int first, input int last_idx, input int tlast_idx);
    for (int i = first; i <= last_idx; i++) send_beat(i, i == tlast_idx);
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
    tick();
  endtask

  task automatic check_words(input string tag, input int n);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n && i < got_q.size(); i++)
      chk({tag, "_word"}, got_q[i], base + 32'(i));
  endtask

  int d0, c0, h0, r0;

  initial begin
    rst = 1'b1;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    start = 1'b0; abort = 1'b0; input_channel_size = '0; cfg_rows = '0;
    fifo_full = 1'b0; fifo_empty = 1'b1; fifo_read = 1'b0;
    base = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_clear", 32'(axis_clear), 32'd0);
    chk("rst_load", 32'(load_axis_preload), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err_tlast), 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);
    rst = 1'b0;
    tick();

    // Frame 1: ch=12 rows=2 (3 beats per row), mid-frame start ignored
    base = 32'h0ABC_1000; got_q.delete(); d0 = done_cnt; c0 = clear_cnt;
    do_start(12'd12, 16'd2);
    chk("t1_clear", 32'(axis_clear), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_tready", 32'(s_axis_tready), 32'd1);
    send_range(0, 1, 5);
    do_start(12'd3, 16'd0);
    chk("t1_restart_clear", 32'(axis_clear), 32'd0);
    chk("t1_restart_busy", 32'(busy), 32'd1);
    send_range(2, 5, 5);
    wait_done("t1_done");
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);
    check_words("t1", 6);
    chk("t1_err", 32'(err_tlast), 32'd0);
    chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("t1_clear_cnt", 32'(clear_cnt - c0), 32'd1);

    // Frame 2: fifo_full held for 10 cycles after the first beat
    base = 32'h0ABC_2000; got_q.delete(); h0 = hold_cnt;
    do_start(12'd12, 16'd2);
    send_beat(0, 1'b0);
    fifo_full = 1'b1;
    fork
      begin
        repeat (10) @(posedge clk);
        #1 fifo_full = 1'b0;
      end
    join_none
    send_range(1, 5, 5);
    wait_done("t2_done");
    check_words("t2", 6);
    chk("t2_tready_drop", 32'(hold_cnt > h0), 32'd1);
    chk("t2_err", 32'(err_tlast), 32'd0);

    // Frame 3: fifo_full held 7 cycles while the skid holds data
    base = 32'h0ABC_3000; got_q.delete();
    do_start(12'd12, 16'd2);
    send_beat(0, 1'b0);
    fifo_full = 1'b1;
    fork
      begin
        repeat (7) @(posedge clk);
        #1 fifo_full = 1'b0;
      end
    join_none
    send_range(1, 5, 5);
    wait_done("t3_done");
    check_words("t3", 6);
    chk("t3_stall", stall_cnt, EXP_STALL7);

    // Frame 4: tlast on the third beat
    base = 32'h0ABC_4000; got_q.delete(); d0 = done_cnt;
    do_start(12'd12, 16'd2);
    send_range(0, 5, 2);
    wait_done("t4_done");
    check_words("t4", 6);
    chk("t4_err", 32'(err_tlast), 32'd1);
    repeat (3) tick();
    chk("t4_err_sticky", 32'(err_tlast), 32'd1);
    chk("t4_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Frame 5: abort after four beats with a fifth beat offered
    base = 32'h0ABC_5000; got_q.delete(); d0 = done_cnt; c0 = clear_cnt;
    do_start(12'd12, 16'd2);
    chk("t5_err_cleared", 32'(err_tlast), 32'd0);
    send_range(0, 3, 5);
    s_axis_tdata = base + 32'd4; s_axis_tvalid = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk("t5_abort_tready", 32'(s_axis_tready), 32'd0);
    chk("t5_abort_load", 32'(load_axis_preload), 32'd0);
    tick();
    abort = 1'b0; s_axis_tvalid = 1'b0;
    chk("t5_clear", 32'(axis_clear), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_tready", 32'(s_axis_tready), 32'd0);
    tick();
    chk("t5_clear_off", 32'(axis_clear), 32'd0);
    repeat (10) tick();
    check_words("t5", 3);
    chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t5_clear_cnt", 32'(clear_cnt - c0), 32'd2);

    // Frame 6: zero rows
    r0 = rdy_cnt; d0 = done_cnt;
    do_start(12'd7, 16'd0);
    chk("t6_clear", 32'(axis_clear), 32'd1);
    chk("t6_done", 32'(done), 32'd1);
    tick();
    chk("t6_done_off", 32'(done), 32'd0);
    chk("t6_idle", 32'(busy), 32'd0);
    repeat (3) tick();
    chk("t6_no_tready", 32'(rdy_cnt - r0), 32'd0);
    chk("t6_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Frame 7: ch=6 rows=2 (2 beats per row), FIFO full but being read
    base = 32'h0ABC_7000; got_q.delete();
    fifo_full = 1'b1; fifo_read = 1'b1; fifo_empty = 1'b1;
    do_start(12'd6, 16'd2);
    send_beat(0, 1'b0);
    @(negedge clk);
    chk("t7_blocked", 32'(load_axis_preload), 32'd0);
    tick();
    fifo_empty = 1'b0;
    send_range(1, 3, 3);
    wait_done("t7_done");
    check_words("t7", 4);
    chk("t7_err", 32'(err_tlast), 32'd0);
    fifo_full = 1'b0; fifo_read = 1'b0; fifo_empty = 1'b1;

    // Asynchronous reset mid-frame
    base = 32'h0ABC_8000;
    do_start(12'd12, 16'd2);
    send_range(0, 1, 5);
    #3 rst = 1'b1;
    #1;
    chk("t8_busy", 32'(busy), 32'd0);
    chk("t8_tready", 32'(s_axis_tready), 32'd0);
    chk("t8_load", 32'(load_axis_preload), 32'd0);
    chk("t8_clear", 32'(axis_clear), 32'd0);
    tick();
    chk("t8_clear_after", 32'(axis_clear), 32'd0);
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
